// File: rtl/capture_route_ctrl.sv
// rtl/capture_route_ctrl.sv - capture holdoff FSM with programmable ADC-to-buffer/DAC stream router
//
// Purpose: re-arms the capture engine after a programmable holdoff and routes ADC
// beats to output streams, either straight (repacked) or as half-history/half-current
// "extend" beats. Register file holds ID, HOLDOFF, CTRL, STATUS and per-output ROUTE.
//
// Ports:
//   i_aclk             stream, config and FSM clock
//   i_areset           asynchronous active-high reset
//   i_cfg_wr/i_cfg_rd  register write/read strobes
//   i_cfg_addr         word address
//   i_cfg_wdata        write data
//   o_cfg_rdata        registered read data (updates the cycle after i_cfg_rd)
//   i_capture_waiting  capture engine idle/waiting
//   o_capture_enable   trigger permitted (registered, high while ARMED)
//   i_in_tdata         NCH beats, lane k of ch c at [(c*NSAMP+k)*16 +: 16]
//   i_in_tvalid        per-channel valid
//   o_out_tdata        NOUT beats, same layout
//   o_out_tvalid       per-output valid
module capture_route_ctrl #(
  parameter int NCH      = 8,
  parameter int NOUT     = 6,
  parameter int NSAMP    = 8,
  parameter int NBITS    = 12,
  parameter int CNT_W    = 32,
  parameter int HOLD_RST = 175000000
) (
  input  logic                      i_aclk,
  input  logic                      i_areset,
  input  logic                      i_cfg_wr,
  input  logic                      i_cfg_rd,
  input  logic [4:0]                i_cfg_addr,
  input  logic [31:0]               i_cfg_wdata,
  output logic [31:0]               o_cfg_rdata,
  input  logic                      i_capture_waiting,
  output logic                      o_capture_enable,
  input  logic [NCH*NSAMP*16-1:0]   i_in_tdata,
  input  logic [NCH-1:0]            i_in_tvalid,
  output logic [NOUT*NSAMP*16-1:0]  o_out_tdata,
  output logic [NOUT-1:0]           o_out_tvalid
);

  localparam int BEAT_W = NSAMP * 16;
  localparam int HALF_W = BEAT_W / 2;
  // Keeps the NBITS MSB-justified sample bits of a lane, forces the pad bits to 0.
  localparam logic [15:0] LANE_MASK = 16'(16'hFFFF << (16 - NBITS));

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_HOLDOFF  = 2'd1,
    ST_ARMED    = 2'd2
  } state_t;

  // ---------------- configuration registers ----------------
  logic [CNT_W-1:0] r_holdoff;
  logic             r_auto_rearm;
  logic [3:0]       r_route_src  [NOUT];
  logic [NOUT-1:0]  r_route_mode;
  logic [NOUT-1:0]  r_route_en;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_arm_cnt;
  logic             r_cap_en;

  logic             w_wr_holdoff;
  logic             w_wr_ctrl;
  logic             w_force_arm;
  logic [31:0]      w_rdata;

  assign w_wr_holdoff = i_cfg_wr && (i_cfg_addr == 5'h01);
  assign w_wr_ctrl    = i_cfg_wr && (i_cfg_addr == 5'h02);
  assign w_force_arm  = w_wr_ctrl && i_cfg_wdata[1];

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_holdoff    <= CNT_W'(HOLD_RST);
      r_auto_rearm <= 1'b1;
      r_route_mode <= '0;
      r_route_en   <= '1;
      for (int o = 0; o < NOUT; o++) r_route_src[o] <= 4'(o % NCH);
    end else begin
      if (w_wr_holdoff) r_holdoff <= CNT_W'(i_cfg_wdata);
      if (w_wr_ctrl) r_auto_rearm <= i_cfg_wdata[0];
      for (int o = 0; o < NOUT; o++) begin
        if (i_cfg_wr && (i_cfg_addr == 5'(16 + o))) begin
          r_route_src[o]  <= i_cfg_wdata[3:0];
          r_route_mode[o] <= i_cfg_wdata[8];
          r_route_en[o]   <= i_cfg_wdata[9];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_cfg_addr)
      5'h00:   w_rdata = 32'h5254_4531;
      5'h01:   w_rdata = 32'(r_holdoff);
      5'h02:   w_rdata = {31'd0, r_auto_rearm};
      5'h03:   w_rdata = {r_arm_cnt, 14'd0, r_state};
      default: begin
        for (int o = 0; o < NOUT; o++) begin
          if (i_cfg_addr == 5'(16 + o))
            w_rdata = {22'd0, r_route_en[o], r_route_mode[o], 4'd0, r_route_src[o]};
        end
      end
    endcase
  end

  // Read data is sampled before any same-cycle write lands, so a
  // simultaneous read/write of one address returns the old value.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) o_cfg_rdata <= '0;
    else if (i_cfg_rd) o_cfg_rdata <= w_rdata;
  end

  // ---------------- holdoff FSM ----------------
  logic w_hold_done;
  logic w_hold_zero;

  // counter >= HOLDOFF-1, computed as counter+1 >= HOLDOFF so HOLDOFF=0 cannot underflow.
  assign w_hold_done = ({1'b0, r_cnt} + (CNT_W+1)'(1)) >= {1'b0, r_holdoff};
  assign w_hold_zero = (r_holdoff == '0);

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state   <= ST_ARMED;
      r_cap_en  <= 1'b1;
      r_cnt     <= '0;
      r_arm_cnt <= '0;
    end else if (w_force_arm) begin
      r_state  <= ST_ARMED;
      r_cap_en <= 1'b1;
      r_cnt    <= '0;
      if (r_state != ST_ARMED) r_arm_cnt <= r_arm_cnt + 16'd1;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (!i_capture_waiting) begin
            r_state  <= ST_DISARMED;
            r_cap_en <= 1'b0;
          end
        end
        ST_DISARMED: begin
          if (i_capture_waiting && r_auto_rearm) begin
            if (w_hold_zero) begin
              r_state   <= ST_ARMED;
              r_cap_en  <= 1'b1;
              r_arm_cnt <= r_arm_cnt + 16'd1;
            end else begin
              r_state <= ST_HOLDOFF;
            end
            r_cnt <= '0;
          end
        end
        ST_HOLDOFF: begin
          if (!i_capture_waiting) begin
            r_state <= ST_DISARMED;
            r_cnt   <= '0;
          end else if (w_hold_done) begin
            r_state   <= ST_ARMED;
            r_cap_en  <= 1'b1;
            r_arm_cnt <= r_arm_cnt + 16'd1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_DISARMED;
          r_cap_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_capture_enable = r_cap_en;

  // ---------------- stream router ----------------
  logic [BEAT_W-1:0] w_rep [NCH];
  logic [HALF_W-1:0] r_hist [NCH];     // only the lower half-beat is ever replayed
  logic [NCH-1:0]    r_hist_v;

  for (genvar c = 0; c < NCH; c++) begin : g_rep
    assign w_rep[c] = i_in_tdata[c*BEAT_W +: BEAT_W] & {NSAMP{LANE_MASK}};
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      for (int c = 0; c < NCH; c++) r_hist[c] <= '0;
      r_hist_v <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (i_in_tvalid[c]) begin
          r_hist[c]   <= w_rep[c][HALF_W-1:0];
          r_hist_v[c] <= 1'b1;
        end
      end
    end
  end

  logic [BEAT_W-1:0] w_nxt_data [NOUT];
  logic [NOUT-1:0]   w_nxt_valid;
  logic [NOUT-1:0]   w_src_ok;
  logic [NOUT-1:0]   w_src_v;

  // Source match by loop so an out-of-range src (>= NCH) simply selects nothing.
  always_comb begin
    for (int o = 0; o < NOUT; o++) begin
      w_nxt_data[o]  = '0;
      w_nxt_valid[o] = 1'b0;
      w_src_ok[o]    = 1'b0;
      w_src_v[o]     = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (r_route_en[o] && (r_route_src[o] == 4'(c))) begin
          w_src_ok[o] = 1'b1;
          w_src_v[o]  = i_in_tvalid[c];
          if (r_route_mode[o]) begin
            w_nxt_data[o]  = {w_rep[c][HALF_W-1:0], r_hist[c]};
            w_nxt_valid[o] = i_in_tvalid[c] & r_hist_v[c];
          end else begin
            w_nxt_data[o]  = w_rep[c];
            w_nxt_valid[o] = i_in_tvalid[c];
          end
        end
      end
    end
  end

  logic [NOUT*BEAT_W-1:0] r_out_tdata;
  logic [NOUT-1:0]        r_out_tvalid;

  // Data follows the source's valid beats (so outputs stay 0 after reset until
  // the next valid beat); disabled/unroutable outputs are held at 0.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_out_tdata  <= '0;
      r_out_tvalid <= '0;
    end else begin
      for (int o = 0; o < NOUT; o++) begin
        r_out_tvalid[o] <= w_nxt_valid[o];
        if (!w_src_ok[o]) r_out_tdata[o*BEAT_W +: BEAT_W] <= '0;
        else if (w_src_v[o]) r_out_tdata[o*BEAT_W +: BEAT_W] <= w_nxt_data[o];
      end
    end
  end

  assign o_out_tdata  = r_out_tdata;
  assign o_out_tvalid = r_out_tvalid;

endmodule

// File: tb/tb_capture_route_ctrl.sv
// tb/tb_capture_route_ctrl.sv - directed self-checking bench for capture_route_ctrl
module tb_capture_route_ctrl;

  localparam int NCH   = 8;
  localparam int NOUT  = 6;
  localparam int NSAMP = 8;
  localparam int BW    = NSAMP * 16;

  logic                  i_aclk = 1'b0;
  logic                  i_areset;
  logic                  i_cfg_wr;
  logic                  i_cfg_rd;
  logic [4:0]            i_cfg_addr;
  logic [31:0]           i_cfg_wdata;
  logic [31:0]           o_cfg_rdata;
  logic                  i_capture_waiting;
  logic                  o_capture_enable;
  logic [NCH*BW-1:0]     i_in_tdata;
  logic [NCH-1:0]        i_in_tvalid;
  logic [NOUT*BW-1:0]    o_out_tdata;
  logic [NOUT-1:0]       o_out_tvalid;

  int n_vec  = 0;
  int n_miss = 0;

  capture_route_ctrl dut (
    .i_aclk            (i_aclk),
    .i_areset          (i_areset),
    .i_cfg_wr          (i_cfg_wr),
    .i_cfg_rd          (i_cfg_rd),
    .i_cfg_addr        (i_cfg_addr),
    .i_cfg_wdata       (i_cfg_wdata),
    .o_cfg_rdata       (o_cfg_rdata),
    .i_capture_waiting (i_capture_waiting),
    .o_capture_enable  (o_capture_enable),
    .i_in_tdata        (i_in_tdata),
    .i_in_tvalid       (i_in_tvalid),
    .o_out_tdata       (o_out_tdata),
    .o_out_tvalid      (o_out_tvalid)
  );

  always #5 i_aclk = ~i_aclk;

  task automatic step();
    @(posedge i_aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    i_cfg_wr = 1'b1; i_cfg_addr = addr; i_cfg_wdata = data;
    step();
    i_cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data);
    i_cfg_rd = 1'b1; i_cfg_addr = addr;
    step();
    i_cfg_rd = 1'b0;
    data = o_cfg_rdata;
  endtask

  // Returns the step index at which enable is first seen high, -1 if the bound expires.
  task automatic wait_enable(input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (o_capture_enable === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic [BW-1:0] exp_beat;
  int cyc;

  initial begin
    i_areset = 1'b1; i_cfg_wr = 1'b0; i_cfg_rd = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0;
    i_capture_waiting = 1'b1; i_in_tdata = '0; i_in_tvalid = '0;
    step(); step();
    i_areset = 1'b0;
    step();

    // ---- reset state ----
    check("rst_enable", BW'(o_capture_enable), BW'(1));
    check("rst_rdata", BW'(o_cfg_rdata), BW'(0));
    check("rst_tvalid", BW'(o_out_tvalid), BW'(0));
    cfg_read(5'h01, rd); check("rst_holdoff", BW'(rd), BW'(32'd175000000));
    cfg_read(5'h03, rd); check("rst_status", BW'(rd), BW'(32'h0000_0002));
    cfg_read(5'h10, rd); check("rst_route0", BW'(rd), BW'(32'h0000_0200));

    // ---- T1: HOLDOFF=5, enable 6 cycles after waiting rises ----
    cfg_write(5'h01, 32'd5);
    i_capture_waiting = 1'b0;
    step();
    check("t1_disarmed_en", BW'(o_capture_enable), BW'(0));
    step();
    i_capture_waiting = 1'b1;
    wait_enable(20, cyc);
    check("t1_enable_delay", BW'(cyc), BW'(6));
    cfg_read(5'h03, rd); check("t1_status", BW'(rd), BW'(32'h0001_0002));

    // ---- T2: HOLDOFF=100, abort at holdoff cycle 40, full restart ----
    cfg_write(5'h01, 32'd100);
    i_capture_waiting = 1'b0;
    step();
    i_capture_waiting = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("t2_mid_holdoff_en", BW'(o_capture_enable), BW'(0));
    i_capture_waiting = 1'b0;
    step();
    cfg_read(5'h03, rd); check("t2_abort_state", BW'(rd), BW'(32'h0001_0000));
    i_capture_waiting = 1'b1;
    wait_enable(300, cyc);
    check("t2_enable_delay", BW'(cyc), BW'(101));
    cfg_read(5'h03, rd); check("t2_status", BW'(rd), BW'(32'h0002_0002));

    // ---- T3: auto_rearm off, force_arm ----
    cfg_write(5'h02, 32'h0);
    i_capture_waiting = 1'b0; step();
    i_capture_waiting = 1'b1; step();
    i_capture_waiting = 1'b0; step();
    i_capture_waiting = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t3_stay_disarmed_en", BW'(o_capture_enable), BW'(0));
    cfg_read(5'h03, rd); check("t3_status_disarmed", BW'(rd), BW'(32'h0002_0000));
    cfg_write(5'h02, 32'h2);
    check("t3_force_en", BW'(o_capture_enable), BW'(1));
    cfg_read(5'h02, rd); check("t3_ctrl_read", BW'(rd), BW'(32'h0));
    cfg_read(5'h03, rd); check("t3_status_armed", BW'(rd), BW'(32'h0003_0002));

    // ---- T4: extend mode on ROUTE[1] from ch0 ----
    cfg_write(5'h11, 32'h0000_0300);
    cfg_read(5'h11, rd); check("t4_route1_read", BW'(rd), BW'(32'h0000_0300));
    for (int k = 0; k < NSAMP; k++) i_in_tdata[k*16 +: 16] = {12'(k), 4'hF};
    i_in_tvalid = 8'h01;
    step();
    check("t4_first_tvalid1", BW'(o_out_tvalid[1]), BW'(0));
    for (int k = 0; k < NSAMP; k++) exp_beat[k*16 +: 16] = {12'(k), 4'h0};
    check("t4_out0_repack", o_out_tdata[0 +: BW], exp_beat);
    check("t4_out0_tvalid", BW'(o_out_tvalid[0]), BW'(1));
    for (int k = 0; k < NSAMP; k++) i_in_tdata[k*16 +: 16] = {12'(k + 16), 4'hF};
    step();
    check("t4_second_tvalid1", BW'(o_out_tvalid[1]), BW'(1));
    for (int k = 0; k < NSAMP; k++)
      exp_beat[k*16 +: 16] = (k < 4) ? {12'(k), 4'h0} : {12'(k - 4 + 16), 4'h0};
    check("t4_out1_extend", o_out_tdata[BW +: BW], exp_beat);
    i_in_tvalid = '0;
    step();
    check("t4_idle_tvalid", BW'(o_out_tvalid), BW'(0));

    // ---- T5: disabled / out-of-range routes, ID and unmapped reads ----
    cfg_write(5'h12, 32'h0000_0002);
    cfg_write(5'h13, 32'h0000_020F);
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NSAMP; k++)
        i_in_tdata[(c*NSAMP + k)*16 +: 16] = 16'(c*256 + k*16 + 15);
    i_in_tvalid = '1;
    step();
    check("t5_out2_data", o_out_tdata[2*BW +: BW], '0);
    check("t5_out3_data", o_out_tdata[3*BW +: BW], '0);
    check("t5_out23_tvalid", BW'(o_out_tvalid[3:2]), BW'(0));
    for (int k = 0; k < NSAMP; k++) exp_beat[k*16 +: 16] = 16'(4*256 + k*16);
    check("t5_out4_data", o_out_tdata[4*BW +: BW], exp_beat);
    check("t5_out4_tvalid", BW'(o_out_tvalid[4]), BW'(1));
    cfg_read(5'h00, rd); check("t5_id", BW'(rd), BW'(32'h5254_4531));
    cfg_read(5'h09, rd); check("t5_unmapped", BW'(rd), BW'(0));
    cfg_read(5'h1F, rd); check("t5_route_oob", BW'(rd), BW'(0));

    // ---- T6: async reset mid-HOLDOFF with traffic ----
    cfg_write(5'h02, 32'h1);
    cfg_write(5'h01, 32'd1000);
    i_capture_waiting = 1'b0; step();
    i_capture_waiting = 1'b1; step(); step(); step();
    check("t6_pre_reset_en", BW'(o_capture_enable), BW'(0));
    i_areset = 1'b1;
    #2;
    check("t6_async_en", BW'(o_capture_enable), BW'(1));
    check("t6_async_tvalid", BW'(o_out_tvalid), BW'(0));
    check("t6_async_tdata", BW'(|o_out_tdata), BW'(0));
    i_areset = 1'b0;
    i_in_tvalid = '0;
    step();
    check("t6_idle_tdata", BW'(|o_out_tdata), BW'(0));
    cfg_read(5'h01, rd); check("t6_holdoff", BW'(rd), BW'(32'd175000000));
    cfg_read(5'h11, rd); check("t6_route1", BW'(rd), BW'(32'h0000_0201));
    cfg_read(5'h12, rd); check("t6_route2", BW'(rd), BW'(32'h0000_0202));
    cfg_read(5'h13, rd); check("t6_route3", BW'(rd), BW'(32'h0000_0203));
    cfg_read(5'h03, rd); check("t6_status", BW'(rd), BW'(32'h0000_0002));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
